rvx_spi_responder: RTL

RVX_SPI_RESPONDER -- requirements
Module: rvx_spi_responder

---
 rtl/rvx_spi_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rvx_spi_responder.sv
// SPI mode-0 responder: 8-bit MSB-first frames, one-deep TX holding register.
// Ports: clock/reset system side; sclk/mosi/cs/miso serial side;
//   tx_data/tx_valid/tx_ready TX holding register load; rx_data/rx_valid
//   received byte; tx_underrun pulse when IDLE_BYTE is sent; busy in SHIFT.
module rvx_spi_responder #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic       cs,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       under_q, under_d;
  logic       load;
  logic       accept;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // Edges are taken between the last sync stage and one more register,
  // so every detector sees only synchronized values.
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      under_q     <= under_d;
    end
  end

  assign accept = tx_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    under_d     = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = 3'd0;
          rx_sr_d = 8'h00;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          // Any partial byte is dropped here; its TX byte is gone.
          state_d = IDLE;
          cnt_d   = 3'd0;
          rx_sr_d = 8'h00;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[6:0], mosi_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = {rx_sr_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (cnt_q == 3'd0) begin
            load = 1'b1;
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load sees the register as it was before this cycle's accept,
    // so a byte arriving with the load waits for the next one.
    if (load) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d = IDLE_BYTE;
        under_d = 1'b1;
      end
    end

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign busy        = (state_q == SHIFT);
  assign miso        = busy & tx_sr_q[7];
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = under_q;

endmodule
